// File: rtl/spi_line_fetch_pkg.sv
// Shared definitions for the SPI/QSPI line-fetch engine: FSM encoding, default opcodes
// and a small helper for sizing the shared phase counter.
package spi_line_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DUMMY = 3'd3,
    ST_DATA  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [7:0] CMD_SINGLE_DEF = 8'h03;
  localparam logic [7:0] CMD_QUAD_DEF   = 8'h6B;
  localparam int         CMD_BITS       = 8;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_line_buffer.sv
// Ping-pong line buffer: two banks of DATA_BITS bits, 1-bit or 4-bit write into the back
// bank, combinational single-bit read of the front bank.
module spi_line_buffer #(
  parameter int DATA_BITS = 136,
  parameter int IDX_W     = $clog2(DATA_BITS)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic             wr_bank_i,
  input  logic             wr_quad_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [3:0]       wr_nib_i,
  input  logic             rd_bank_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_data_o
);

  logic [DATA_BITS-1:0] bank_q [2];
  logic [3:0]           nib_rev;

  // io3 lands at the lowest index of the nibble
  assign nib_rev = {wr_nib_i[0], wr_nib_i[1], wr_nib_i[2], wr_nib_i[3]};

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < DATA_BITS; i++) begin
        if (wr_quad_i) begin
          if ((32'(i) - 32'(wr_idx_i)) < 32'd4)
            bank_q[wr_bank_i][i] <= nib_rev[2'(32'(i) - 32'(wr_idx_i))];
        end else if (32'(i) == 32'(wr_idx_i)) begin
          bank_q[wr_bank_i][i] <= wr_nib_i[1];
        end
      end
    end
  end

  always_comb begin
    rd_data_o = 1'b0;
    if (32'(rd_idx_i) < 32'(DATA_BITS))
      rd_data_o = bank_q[rd_bank_i][rd_idx_i];
  end

endmodule

// File: rtl/spi_line_fetch.sv
// SPI/QSPI flash line-fetch engine: one READ (03h) or QUAD OUTPUT FAST READ (6Bh) per start,
// data captured into the back bank of a ping-pong buffer, banks swapped on completion.
//
//   state    | meaning
//   ST_IDLE  | cs low, waiting for start
//   ST_CMD   | shifting 8-bit opcode out on io0
//   ST_ADDR  | shifting address out on io0, MSB first
//   ST_DUMMY | quad only: io0 released, dummy clocks
//   ST_DATA  | capturing data into back bank
//   ST_DONE  | cs low, done pulse, banks swapped
module spi_line_fetch
  import spi_line_fetch_pkg::*;
#(
  parameter int         DATA_BITS  = 136,
  parameter int         ADDR_BITS  = 24,
  parameter int         QUAD_DUMMY = 8,
  parameter logic [7:0] CMD_SINGLE = CMD_SINGLE_DEF,
  parameter logic [7:0] CMD_QUAD   = CMD_QUAD_DEF
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         quad,
  input  logic [ADDR_BITS-1:0]         addr,
  input  logic                         abort,
  output logic                         busy,
  output logic                         done,
  output logic                         front_bank,
  input  logic [$clog2(DATA_BITS)-1:0] rd_index,
  output logic                         rd_data,
  output logic                         spi_cs,
  output logic                         spi_sclk,
  input  logic [3:0]                   spi_in,
  output logic                         spi_out0,
  output logic                         spi_dir0
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam int CNT_W = $clog2(max_i(max_i(DATA_BITS, ADDR_BITS), max_i(CMD_BITS, QUAD_DUMMY)));

  localparam logic [CNT_W-1:0] CMD_LEN_M1   = CNT_W'(CMD_BITS - 1);
  localparam logic [CNT_W-1:0] ADDR_LEN_M1  = CNT_W'(ADDR_BITS - 1);
  localparam logic [CNT_W-1:0] DUMMY_LEN_M1 = CNT_W'((QUAD_DUMMY > 0) ? QUAD_DUMMY - 1 : 0);
  localparam logic [CNT_W-1:0] SDATA_LEN_M1 = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] QDATA_LEN_M1 = CNT_W'(DATA_BITS / 4 - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 quad_q, quad_d;
  logic [7:0]           cmd_q, cmd_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 front_q, front_d;
  logic [3:0]           cap_q;

  logic [CNT_W-1:0]     data_len_m1;
  logic [CNT_W-1:0]     beat;
  logic [IDX_W-1:0]     wr_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      quad_q  <= 1'b0;
      cmd_q   <= '0;
      addr_q  <= '0;
      front_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quad_q  <= quad_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      front_q <= front_d;
    end
  end

  // Flash drives on falling SCLK; sample on rising SCLK, i.e. falling clk
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) cap_q <= '0;
    else          cap_q <= spi_in;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quad_d  = quad_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    front_d = front_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CMD;
          cnt_d   = CMD_LEN_M1;
          quad_d  = quad;
          cmd_d   = quad ? CMD_QUAD : CMD_SINGLE;
          addr_d  = addr;
        end
      end
      ST_CMD: begin
        cmd_d = {cmd_q[6:0], 1'b0};
        if (cnt_q == '0) begin
          state_d = ST_ADDR;
          cnt_d   = ADDR_LEN_M1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ADDR: begin
        addr_d = {addr_q[ADDR_BITS-2:0], 1'b0};
        if (cnt_q == '0) begin
          if (quad_q && (QUAD_DUMMY > 0)) begin
            state_d = ST_DUMMY;
            cnt_d   = DUMMY_LEN_M1;
          end else begin
            state_d = ST_DATA;
            cnt_d   = quad_q ? QDATA_LEN_M1 : SDATA_LEN_M1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DUMMY: begin
        if (cnt_q == '0) begin
          state_d = ST_DATA;
          cnt_d   = QDATA_LEN_M1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          front_d = ~front_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      front_d = front_q;
    end
  end

  assign data_len_m1 = quad_q ? QDATA_LEN_M1 : SDATA_LEN_M1;
  assign beat        = data_len_m1 - cnt_q;
  assign wr_idx      = quad_q ? IDX_W'({beat, 2'b00}) : IDX_W'(beat);

  assign spi_cs     = (state_q == ST_CMD) || (state_q == ST_ADDR) ||
                      (state_q == ST_DUMMY) || (state_q == ST_DATA);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign front_bank = front_q;
  assign spi_sclk   = ~clk;
  assign spi_dir0   = quad_q && ((state_q == ST_DUMMY) || (state_q == ST_DATA));
  assign spi_out0   = (state_q == ST_CMD)  ? cmd_q[7] :
                      (state_q == ST_ADDR) ? addr_q[ADDR_BITS-1] : 1'b0;

  spi_line_buffer #(
    .DATA_BITS (DATA_BITS),
    .IDX_W     (IDX_W)
  ) u_buf (
    .clk       (clk),
    .we_i      (state_q == ST_DATA),
    .wr_bank_i (~front_q),
    .wr_quad_i (quad_q),
    .wr_idx_i  (wr_idx),
    .wr_nib_i  (cap_q),
    .rd_bank_i (front_q),
    .rd_idx_i  (rd_index),
    .rd_data_o (rd_data)
  );

endmodule
